// File: rtl/i2c_target_regs.sv
// I2C target exposing a byte-wide register file with a pointer byte and auto-increment.
// Open-drain SDA, no clock stretching; SCL/SDA are oversampled on i_clk.
module i2c_target_regs #(
  parameter logic [6:0]  I2C_ADDR = 7'h48,
  parameter int unsigned NUM_REGS = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_scl,
  inout  wire                         io_sda,
  output logic [8*NUM_REGS-1:0]       o_regs,
  output logic                        o_wr_strobe,
  output logic [$clog2(NUM_REGS)-1:0] o_wr_index,
  output logic                        o_busy
);

  localparam int unsigned IW = $clog2(NUM_REGS);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, IGNORE, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK
  } state_t;

  logic [2:0] scl_sync, sda_sync;
  logic       scl_hi, scl_rise, scl_fall, sda_in, start_det, stop_det;

  state_t                     state_q, state_n;
  logic [3:0]                 cnt_q, cnt_n;
  logic [7:0]                 shreg_q, shreg_n;
  logic [IW-1:0]              ptr_q, ptr_n;
  logic                       sda_low_q, sda_low_n;
  logic                       rw_q, rw_n;
  logic                       nack_q, nack_n;
  logic [NUM_REGS-1:0][7:0]   regs_q, regs_n;
  logic                       wr_strobe_q, wr_strobe_n;
  logic [IW-1:0]              wr_index_q, wr_index_n;
  logic                       busy_q, busy_n;

  // Two-stage synchronizers plus one history stage for edge detection; idle bus reads high.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scl_sync <= 3'b111;
      sda_sync <= 3'b111;
    end else begin
      scl_sync <= {scl_sync[1:0], i_scl};
      sda_sync <= {sda_sync[1:0], io_sda};
    end
  end

  assign scl_hi    = scl_sync[1] & scl_sync[2];
  assign scl_rise  = scl_sync[1] & ~scl_sync[2];
  assign scl_fall  = ~scl_sync[1] & scl_sync[2];
  assign sda_in    = sda_sync[1];
  assign start_det = scl_hi & sda_sync[2] & ~sda_sync[1];
  assign stop_det  = scl_hi & ~sda_sync[2] & sda_sync[1];

  // Next-state and datapath updates; START/STOP override every state.
  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    shreg_n     = shreg_q;
    ptr_n       = ptr_q;
    sda_low_n   = sda_low_q;
    rw_n        = rw_q;
    nack_n      = nack_q;
    regs_n      = regs_q;
    wr_strobe_n = 1'b0;
    wr_index_n  = wr_index_q;

    if (start_det) begin
      state_n   = ADDR;
      cnt_n     = 4'd0;
      sda_low_n = 1'b0;
    end else if (stop_det) begin
      state_n   = IDLE;
      sda_low_n = 1'b0;
    end else begin
      case (state_q)
        ADDR, PTR, WDATA: begin
          if (scl_rise && cnt_q != 4'd8) begin
            shreg_n = {shreg_q[6:0], sda_in};
            cnt_n   = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            cnt_n = 4'd0;
            if (state_q == ADDR) begin
              if (shreg_q[7:1] == I2C_ADDR) begin
                sda_low_n = 1'b1;
                rw_n      = shreg_q[0];
                state_n   = ADDR_ACK;
              end else begin
                state_n   = IGNORE;
              end
            end else if (state_q == PTR) begin
              ptr_n     = shreg_q[IW-1:0];
              sda_low_n = 1'b1;
              state_n   = PTR_ACK;
            end else begin
              regs_n[ptr_q] = shreg_q;
              wr_strobe_n   = 1'b1;
              wr_index_n    = ptr_q;
              ptr_n         = ptr_q + IW'(1);
              sda_low_n     = 1'b1;
              state_n       = WDATA_ACK;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (rw_q) begin
              shreg_n   = regs_q[ptr_q];
              sda_low_n = ~regs_q[ptr_q][7];
              cnt_n     = 4'd1;
              state_n   = RDATA;
            end else begin
              sda_low_n = 1'b0;
              cnt_n     = 4'd0;
              state_n   = PTR;
            end
          end
        end
        PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            sda_low_n = 1'b0;
            cnt_n     = 4'd0;
            state_n   = WDATA;
          end
        end
        RDATA: begin
          if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_low_n = 1'b0;
              state_n   = RACK;
            end else begin
              shreg_n   = {shreg_q[6:0], 1'b0};
              sda_low_n = ~shreg_q[6];
              cnt_n     = cnt_q + 4'd1;
            end
          end
        end
        RACK: begin
          if (scl_rise) begin
            nack_n = sda_in;
            ptr_n  = ptr_q + IW'(1);
          end else if (scl_fall) begin
            if (!nack_q) begin
              shreg_n   = regs_q[ptr_q];
              sda_low_n = ~regs_q[ptr_q][7];
              cnt_n     = 4'd1;
              state_n   = RDATA;
            end else begin
              state_n   = IGNORE;
            end
          end
        end
        default: ;
      endcase
    end

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      shreg_q     <= 8'd0;
      ptr_q       <= '0;
      sda_low_q   <= 1'b0;
      rw_q        <= 1'b0;
      nack_q      <= 1'b0;
      regs_q      <= '0;
      wr_strobe_q <= 1'b0;
      wr_index_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      shreg_q     <= shreg_n;
      ptr_q       <= ptr_n;
      sda_low_q   <= sda_low_n;
      rw_q        <= rw_n;
      nack_q      <= nack_n;
      regs_q      <= regs_n;
      wr_strobe_q <= wr_strobe_n;
      wr_index_q  <= wr_index_n;
      busy_q      <= busy_n;
    end
  end

  // Open drain: only ever pull low; reset clears the drive register asynchronously.
  assign io_sda      = sda_low_q ? 1'b0 : 1'bz;
  assign o_regs      = regs_q;
  assign o_wr_strobe = wr_strobe_q;
  assign o_wr_index  = wr_index_q;
  assign o_busy      = busy_q;

endmodule
